// File: rtl/ram_pkg.sv
// Shared constants for the burst data RAM: state encoding, clog2 helper, widths.
// Latency: n/a (package). Backpressure: n/a.
package ram_pkg;

  localparam int ADDR_W  = 32;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RAM_IDLE  = 3'd0,
    RAM_WAIT  = 3'd1,
    RAM_BURST = 3'd2
  } ram_state_t;

  function automatic int clog2(input int n);
    for (int r = 0; r < 32; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 32;
  endfunction

  // Counters need at least one bit even when the count range is a single value.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/burst_data_ram_if.sv
// Request/beat bus between the CMU memory port and burst_data_ram; err exists only
// under BURST_RAM_OOR_EN. Latency: wires only. Backpressure: none, cs sampled in IDLE.
interface burst_data_ram_if #(
  parameter int DATA_WIDTH = 32
);
  import ram_pkg::*;

  logic                  cs;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ack;
  logic                  busy;
  logic [STATE_W-1:0]    ram_state;
`ifdef BURST_RAM_OOR_EN
  logic                  err;
`endif

  modport master (
    output cs, we, addr, din,
    input  dout, ack, busy, ram_state
`ifdef BURST_RAM_OOR_EN
    , input err
`endif
  );

  modport slave (
    input  cs, we, addr, din,
    output dout, ack, busy, ram_state
`ifdef BURST_RAM_OOR_EN
    , output err
`endif
  );

endinterface

// File: rtl/burst_addr_gen.sv
// Wrapped word index for one beat: block of start_idx plus (start + beat) mod BURST_LEN.
// Latency: combinational. Backpressure: none.
module burst_addr_gen #(
  parameter int IDX_W     = 10,
  parameter int BEAT_W    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic [IDX_W-1:0]  start_idx,
  input  logic [BEAT_W-1:0] beat,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [IDX_W-1:0] MASK = IDX_W'(BURST_LEN - 1);

  logic [IDX_W-1:0] sum;

  // Carry out of the low bits is masked off, so the burst never leaves its block.
  assign sum = start_idx + IDX_W'(beat);
  assign idx = (start_idx & ~MASK) | (sum & MASK);

endmodule

// File: rtl/burst_data_ram.sv
// Block-RAM model serving critical-word-first wrap bursts; optional BURST_RAM_OOR_EN range check.
// Latency: first ack LATENCY+1 cycles after acceptance, BURST_LEN beats, one idle cycle after.
// Backpressure: none; cs only sampled in IDLE, a started burst always completes.
module burst_data_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4,
  parameter int BURST_LEN   = 4
) (
  input  logic            clk,
  input  logic            rst,
  burst_data_ram_if.slave bus
);

  localparam int BYTE_SH = clog2(DATA_WIDTH / 8);
  localparam int IDX_W   = clog2(DEPTH_WORDS);
  localparam int BEAT_W  = cnt_width(BURST_LEN);
  localparam int LAT_W   = cnt_width(LATENCY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  ram_state_t            state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [BEAT_W-1:0]     beat_q, beat_d, rd_beat;
  logic                  we_q;
  logic [IDX_W-1:0]      start_q, wr_idx, rd_idx;
  logic                  accept, last_beat, rd_load, wr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_data, dout_q;
  logic                  unused_addr;

  assign unused_addr = ^bus.addr;
  assign last_beat   = (beat_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RAM_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      we_q    <= 1'b0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      if (accept) begin
        we_q    <= bus.we;
        start_q <= bus.addr[IDX_W+BYTE_SH-1:BYTE_SH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    unique case (state_q)
      RAM_IDLE: begin
        if (bus.cs) begin
          accept  = 1'b1;
          state_d = RAM_WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      RAM_WAIT: begin
        if (lat_q == '0) begin
          state_d = RAM_BURST;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RAM_BURST: begin
        if (last_beat) begin
          state_d = RAM_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = RAM_IDLE;
    endcase
  end

  // Reads prefetch the next beat so dout is already valid in each ack cycle.
  assign rd_beat = (state_q == RAM_BURST) ? beat_q + BEAT_W'(1) : '0;
  assign rd_load = !we_q &&
                   (((state_q == RAM_WAIT) && (lat_q == '0)) ||
                    ((state_q == RAM_BURST) && !last_beat));

  burst_addr_gen #(
    .IDX_W     (IDX_W),
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) u_wr_gen (
    .start_idx (start_q),
    .beat      (beat_q),
    .idx       (wr_idx)
  );

  burst_addr_gen #(
    .IDX_W     (IDX_W),
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) u_rd_gen (
    .start_idx (start_q),
    .beat      (rd_beat),
    .idx       (rd_idx)
  );

`ifdef BURST_RAM_OOR_EN
  localparam int OOR_SH = IDX_W + BYTE_SH;
  logic oor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (accept) begin
      oor_q <= ((bus.addr >> OOR_SH) != '0);
    end
  end

  assign wr_en   = (state_q == RAM_BURST) && we_q && !oor_q;
  assign rd_data = oor_q ? '0 : mem[rd_idx];
  assign bus.err = (state_q == RAM_BURST) && oor_q;
`else
  assign wr_en   = (state_q == RAM_BURST) && we_q;
  assign rd_data = mem[rd_idx];
`endif

  // Array has no reset: contents survive rst, only the controller restarts.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_load) begin
      dout_q <= rd_data;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.ack       = (state_q == RAM_BURST);
  assign bus.busy      = (state_q != RAM_IDLE);
  assign bus.ram_state = state_q;

endmodule
